// File: rtl/accel_csr_multi_pkg.sv
// Shared register map, CTRL bit positions and channel state encoding for the
// multi-channel accelerator CSR block.
package accel_csr_pkg;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_IN   = 2'd1;
    localparam logic [1:0] REG_OUT  = 2'd2;
    localparam logic [1:0] REG_CYC  = 2'd3;

    localparam int unsigned BIT_GO   = 0;
    localparam int unsigned BIT_DONE = 1;
    localparam int unsigned BIT_BUSY = 2;
    localparam int unsigned BIT_OVR  = 3;
    localparam int unsigned BIT_IE   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_e;

endpackage

// File: rtl/accel_csr_multi_if.sv
// Avalon-MM slave bundle between the bus fabric and accel_csr_multi.
interface accel_csr_multi_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] AVS_AVALONSLAVE_ADDRESS;
    logic              AVS_AVALONSLAVE_READ;
    logic              AVS_AVALONSLAVE_WRITE;
    logic [DATA_W-1:0] AVS_AVALONSLAVE_WRITEDATA;
    logic [DATA_W-1:0] AVS_AVALONSLAVE_READDATA;
    logic              AVS_AVALONSLAVE_WAITREQUEST;

    modport master (
        output AVS_AVALONSLAVE_ADDRESS, AVS_AVALONSLAVE_READ, AVS_AVALONSLAVE_WRITE,
               AVS_AVALONSLAVE_WRITEDATA,
        input  AVS_AVALONSLAVE_READDATA, AVS_AVALONSLAVE_WAITREQUEST
    );

    modport slave (
        input  AVS_AVALONSLAVE_ADDRESS, AVS_AVALONSLAVE_READ, AVS_AVALONSLAVE_WRITE,
               AVS_AVALONSLAVE_WRITEDATA,
        output AVS_AVALONSLAVE_READDATA, AVS_AVALONSLAVE_WAITREQUEST
    );
endinterface

// File: rtl/accel_csr_multi_channel.sv
// One accelerator channel: IDLE/RUN/DONE FSM, offsets, sticky status, run counter.
// ACCEL_CSR_IRQ_EN adds the IE bit and an interrupt source output.
module accel_csr_channel
    import accel_csr_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [1:0]        reg_sel_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              done_i,
`ifdef ACCEL_CSR_IRQ_EN
    output logic              irq_src_o,
`endif
    output logic              go_o,
    output logic [DATA_W-1:0] in_ofs_o,
    output logic [DATA_W-1:0] out_ofs_o,
    output logic [DATA_W-1:0] rdata_c_o
);
    ch_state_e         state_q;
    logic              go_q, done_q, ovr_q, ie_c;
    logic [DATA_W-1:0] cyc_q, in_ofs_q, out_ofs_q;
    logic              ctrl_wr_c, in_wr_c, out_wr_c, run_c;
    logic [4:0]        ctrl_c;

    assign ctrl_wr_c = wr_en_i && (reg_sel_i == REG_CTRL);
    assign in_wr_c   = wr_en_i && (reg_sel_i == REG_IN);
    assign out_wr_c  = wr_en_i && (reg_sel_i == REG_OUT);
    assign run_c     = (state_q == ST_RUN);

    // A CTRL write always wins over a coincident done_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            go_q      <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            cyc_q     <= '0;
            in_ofs_q  <= '0;
            out_ofs_q <= '0;
        end else begin
            go_q <= 1'b0;
            if (ctrl_wr_c && wdata_i[BIT_OVR]) ovr_q <= 1'b0;
            if (in_wr_c) begin
                if (run_c) ovr_q <= 1'b1;
                else       in_ofs_q <= wdata_i;
            end
            if (out_wr_c) begin
                if (run_c) ovr_q <= 1'b1;
                else       out_ofs_q <= wdata_i;
            end
            case (state_q)
                ST_RUN: begin
                    if (cyc_q != '1) cyc_q <= cyc_q + DATA_W'(1);
                    if (ctrl_wr_c) begin
                        if (wdata_i[BIT_GO]) ovr_q <= 1'b1;
                    end else if (done_i) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    if (ctrl_wr_c && wdata_i[BIT_GO]) begin
                        state_q <= ST_RUN;
                        go_q    <= 1'b1;
                        done_q  <= 1'b0;
                        cyc_q   <= '0;
                    end else if (ctrl_wr_c && wdata_i[BIT_DONE]) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef ACCEL_CSR_IRQ_EN
    logic ie_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          ie_q <= 1'b0;
        else if (ctrl_wr_c) ie_q <= wdata_i[BIT_IE];
    end
    assign ie_c      = ie_q;
    assign irq_src_o = ie_q && (done_q || ovr_q);
`else
    assign ie_c = 1'b0;
`endif

    assign ctrl_c = {ie_c, ovr_q, run_c, done_q, 1'b0};

    always_comb begin
        rdata_c_o = '0;
        case (reg_sel_i)
            REG_CTRL: rdata_c_o = DATA_W'(ctrl_c);
            REG_IN:   rdata_c_o = in_ofs_q;
            REG_OUT:  rdata_c_o = out_ofs_q;
            default:  rdata_c_o = cyc_q;
        endcase
    end

    assign go_o      = go_q;
    assign in_ofs_o  = in_ofs_q;
    assign out_ofs_o = out_ofs_q;
endmodule

// File: rtl/accel_csr_multi.sv
// Avalon-MM CSR slave for NUM_CH accelerator channels: decode, one-wait-state readback.
// ACCEL_CSR_IRQ_EN adds the registered irq output.
module accel_csr_multi
    import accel_csr_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = $clog2(NUM_CH) + 2
) (
    input  logic                     CSI_CLOCK_CLK,
    input  logic                     CSI_CLOCK_RESET,
    accel_csr_multi_if.slave         avs,
    output logic [NUM_CH-1:0]        go,
    input  logic [NUM_CH-1:0]        done,
`ifdef ACCEL_CSR_IRQ_EN
    output logic                     irq,
`endif
    output logic [NUM_CH*DATA_W-1:0] inputAdd_offset,
    output logic [NUM_CH*DATA_W-1:0] outputAdd_offset
);
    localparam int unsigned CH_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;

    logic [CH_W-1:0]   ch_sel_c;
    logic [1:0]        reg_sel_c;
    logic              ch_valid_c, rd_start_c;
    logic [DATA_W-1:0] ch_rdata_c [NUM_CH];
    logic [DATA_W-1:0] rd_mux_c;
    logic              rd_pend_q;
    logic [DATA_W-1:0] rdata_q;
`ifdef ACCEL_CSR_IRQ_EN
    logic [NUM_CH-1:0] irq_src_c;
`endif

    assign reg_sel_c = avs.AVS_AVALONSLAVE_ADDRESS[1:0];
    generate
        if (ADDR_W > 2) begin : g_ch_sel
            assign ch_sel_c = avs.AVS_AVALONSLAVE_ADDRESS[ADDR_W-1:2];
        end else begin : g_ch_fixed
            assign ch_sel_c = '0;
        end
    endgenerate
    assign ch_valid_c = (32'(ch_sel_c) < NUM_CH);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic wr_en_c;
        assign wr_en_c = avs.AVS_AVALONSLAVE_WRITE && ch_valid_c && (32'(ch_sel_c) == 32'(c));
        accel_csr_channel #(.DATA_W(DATA_W)) u_ch (
            .clk_i     (CSI_CLOCK_CLK),
            .rst_i     (CSI_CLOCK_RESET),
            .wr_en_i   (wr_en_c),
            .reg_sel_i (reg_sel_c),
            .wdata_i   (avs.AVS_AVALONSLAVE_WRITEDATA),
            .done_i    (done[c]),
`ifdef ACCEL_CSR_IRQ_EN
            .irq_src_o (irq_src_c[c]),
`endif
            .go_o      (go[c]),
            .in_ofs_o  (inputAdd_offset[c*DATA_W +: DATA_W]),
            .out_ofs_o (outputAdd_offset[c*DATA_W +: DATA_W]),
            .rdata_c_o (ch_rdata_c[c])
        );
    end

    always_comb begin
        rd_mux_c = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_valid_c && (32'(ch_sel_c) == c)) rd_mux_c = ch_rdata_c[c];
        end
    end

    // Stall is combinational so the first read cycle is held off immediately;
    // a read coinciding with a write is dropped.
    assign rd_start_c = avs.AVS_AVALONSLAVE_READ && !avs.AVS_AVALONSLAVE_WRITE && !rd_pend_q;

    always_ff @(posedge CSI_CLOCK_CLK or posedge CSI_CLOCK_RESET) begin
        if (CSI_CLOCK_RESET) begin
            rd_pend_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rd_pend_q <= rd_start_c;
            if (rd_start_c) rdata_q <= rd_mux_c;
        end
    end

    assign avs.AVS_AVALONSLAVE_WAITREQUEST = rd_start_c;
    assign avs.AVS_AVALONSLAVE_READDATA    = rdata_q;

`ifdef ACCEL_CSR_IRQ_EN
    always_ff @(posedge CSI_CLOCK_CLK or posedge CSI_CLOCK_RESET) begin
        if (CSI_CLOCK_RESET) irq <= 1'b0;
        else                 irq <= |irq_src_c;
    end
`endif
endmodule
